sevenseg_scan_driver: RTL and testbench

//  Time-multiplexed N-digit seven-segment display driver. Extends the single-digit decoder:
//  - full hex decode (0-F)
//  - scanned common anodes
//  - per-digit decimal point
//  - leading-zero blanking
//  - frame-coherent data snapshot

---
 rtl/sevenseg_scan_driver_if.sv | 37 +++
 rtl/sevenseg_scan_driver.sv | 151 +++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver_if
//   Bundles the display driver's data inputs and its board-pin outputs.
//   Parameter DIGITS must match the driver instance it is connected to.
//
//   data      4*DIGITS  hex nibbles, digit k = data[4k+3:4k] (digit 0 rightmost)
//   dp_in     DIGITS    decimal point request per digit
//   lz_en     1         blank leading zero digits
//   en        1         0: all anodes inactive (scan keeps running)
//   segments  7         {g,f,e,d,c,b,a} at the pin polarity
//   dp        1         decimal point at the pin polarity
//   anodes    DIGITS    one-hot digit select at the pin polarity
//
//   master: the datapath side (drives data, reads pins)
//   slave : the driver itself
// -----------------------------------------------------------------------------
interface sevenseg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp_in;
    logic                lz_en;
    logic                en;
    logic [6:0]          segments;
    logic                dp;
    logic [DIGITS-1:0]   anodes;

    modport master (
        output data, dp_in, lz_en, en,
        input  segments, dp, anodes
    );

    modport slave (
        input  data, dp_in, lz_en, en,
        output segments, dp, anodes
    );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver
//   Time-multiplexed N-digit seven-segment driver: hex decode, scanned common
//   anodes, per-digit decimal point, leading-zero blanking and a snapshot of
//   data/dp_in taken once per frame so a frame never shows mixed values.
//
//   Parameters
//     DIGITS          1..8, number of digits (digit 0 = rightmost)
//     CLK_DIV         >=2, clocks each digit stays lit
//     SEG_ACTIVE_LOW  1: segments/dp low = lit
//     AN_ACTIVE_LOW   1: anode low = selected
//   Ports
//     clk   system clock, rising edge
//     rst   asynchronous reset, active-high
//     bus   sevenseg_scan_driver_if.slave (data, dp_in, lz_en, en in;
//           segments, dp, anodes out - all outputs registered)
// -----------------------------------------------------------------------------
module sevenseg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    sevenseg_scan_driver_if.slave  bus
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

    // Active-high segment code {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            4'hF: hex_to_seg = 7'h71;
        endcase
    endfunction

    // ---------------------------------------------------------------- state
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [4*DIGITS-1:0] snap_data_reg;
    logic [DIGITS-1:0]   snap_dp_reg;
    logic [6:0]          seg_reg, seg_next;
    logic                dp_reg, dp_next;
    logic [DIGITS-1:0]   an_reg, an_next;

    // ------------------------------------------------------------ prescaler
    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        idx_next = idx_reg;
        if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------- snapshot
    // The snapshot loads on the first clock of digit 0. That same edge also
    // registers digit 0's outputs, so the freshly presented inputs are
    // forwarded past the snapshot register; otherwise digit 0 would show the
    // previous frame's value for one clock.
    logic                snap_load;
    logic [4*DIGITS-1:0] data_eff;
    logic [DIGITS-1:0]   dp_eff;

    assign snap_load = (cnt_reg == '0) && (idx_reg == '0);
    assign data_eff  = snap_load ? bus.data  : snap_data_reg;
    assign dp_eff    = snap_load ? bus.dp_in : snap_dp_reg;

    // ------------------------------------------------------ per-digit views
    logic [3:0]        nib        [DIGITS];
    logic [DIGITS-1:0] upper_zero;  // this nibble and every higher one are 0
    logic [DIGITS-1:0] onehot;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi]        = data_eff[4*gi +: 4];
            assign upper_zero[gi] = (data_eff[4*DIGITS-1 : 4*gi] == '0);
            assign onehot[gi]     = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    // --------------------------------------------------------------- decode
    logic       cur_blank;
    logic [6:0] seg_lit;

    always_comb begin
        // Digit 0 is never blanked so a zero value still shows "0".
        cur_blank = bus.lz_en && (idx_reg != '0) && upper_zero[idx_reg];
        seg_lit   = cur_blank ? 7'h00 : hex_to_seg(nib[idx_reg]);

        seg_next  = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        // Blanking hides segments only; the decimal point still follows dp_in.
        dp_next   = SEG_ACTIVE_LOW ? ~dp_eff[idx_reg] : dp_eff[idx_reg];
        an_next   = AN_OFF;
        if (bus.en) begin
            an_next = AN_ACTIVE_LOW ? ~onehot : onehot;
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            idx_reg       <= '0;
            snap_data_reg <= '0;
            snap_dp_reg   <= '0;
            seg_reg       <= SEG_OFF;
            dp_reg        <= DP_OFF;
            an_reg        <= AN_OFF;
        end else begin
            cnt_reg <= cnt_next;
            idx_reg <= idx_next;
            if (snap_load) begin
                snap_data_reg <= bus.data;
                snap_dp_reg   <= bus.dp_in;
            end
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            an_reg  <= an_next;
        end
    end

    assign bus.segments = seg_reg;
    assign bus.dp       = dp_reg;
    assign bus.anodes   = an_reg;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_driver
//   Frame-level scoreboard bench for sevenseg_scan_driver (DIGITS=4,
//   CLK_DIV=4, active-low segments and anodes). The stimulus process drives
//   one frame at a time and queues the four digit slots it expects to see;
//   the monitor cuts the output stream into CLK_DIV-clock slots counted from
//   reset release, checks each slot is steady and compares it to the queue.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;
    localparam int FRAME   = DIGITS * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sevenseg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    sevenseg_scan_driver #(
        .DIGITS         (DIGITS),
        .CLK_DIV        (CLK_DIV),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         digit;
    } slot_t;

    slot_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    done  = 1'b0;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // What the display should show for digit k of a frame whose snapshot is d/p.
    function automatic slot_t model_slot(input logic [15:0] d, input logic [3:0] p,
                                         input logic lz, input logic e, input int k);
        slot_t      s;
        logic [3:0] nib;
        logic [6:0] lit;
        nib = 4'((d >> (4 * k)) & 16'hF);
        lit = seg_tbl[nib];
        if (lz && k > 0 && (d >> (4 * k)) == 16'h0) lit = 7'h00;
        s.seg   = ~lit;
        s.dp    = ~p[k];
        s.an    = e ? ~(4'b0001 << k) : 4'hF;
        s.digit = k;
        return s;
    endfunction

    task automatic check12(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {an,seg,dp}=%h expected %h", name, act, exp);
        end else begin
            $display("check %s: {an,seg,dp}=%h ok", name, act);
        end
    endtask

    // One frame: inputs set just before the frame's first clock edge, optional
    // mid-frame change after edge chg_at (must not be displayed this frame).
    task automatic frame(input logic [15:0] d, input logic [3:0] p, input logic lz,
                         input logic e, input int chg_at,
                         input logic [15:0] d2, input logic [3:0] p2);
        bus.data  = d;
        bus.dp_in = p;
        bus.lz_en = lz;
        bus.en    = e;
        for (int k = 0; k < DIGITS; k++) sb.push_back(model_slot(d, p, lz, e, k));
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge clk);
            #1;
            if (i == chg_at) begin
                bus.data  = d2;
                bus.dp_in = p2;
            end
        end
    endtask

    // ------------------------------------------------------------- monitor
    initial begin
        int          n_in_slot;
        bit          steady;
        logic [11:0] first, cur;
        slot_t       exp;
        n_in_slot = 0;
        steady    = 1'b1;
        first     = '0;
        forever begin
            @(negedge clk);
            if (rst || done) begin
                n_in_slot = 0;
            end else begin
                cur = {bus.anodes, bus.segments, bus.dp};
                if (n_in_slot == 0) begin
                    first  = cur;
                    steady = 1'b1;
                end else if (cur !== first) begin
                    steady = 1'b0;
                end
                n_in_slot++;
                if (n_in_slot == CLK_DIV) begin
                    n_in_slot = 0;
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL sb_underflow: got slot %h but expected nothing", first);
                    end else begin
                        exp = sb.pop_front();
                        if (!steady || first !== {exp.an, exp.seg, exp.dp}) begin
                            n_bad++;
                            $display("FAIL slot_digit%0d: got {an,seg,dp}=%h steady=%0d expected %h steady=1",
                                     exp.digit, first, steady, {exp.an, exp.seg, exp.dp});
                        end else begin
                            $display("slot digit%0d an=%b seg=%h dp=%b ok",
                                     exp.digit, exp.an, exp.seg, exp.dp);
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [15:0] d, d2;
        logic [3:0]  p, p2;
        logic [31:0] r;

        bus.data  = '0;
        bus.dp_in = '0;
        bus.lz_en = 1'b0;
        bus.en    = 1'b1;

        // Reset takes effect with no clock edge.
        #1 rst = 1'b1;
        #1 check12("reset_immediate", {bus.anodes, bus.segments, bus.dp}, 12'hFFF);
        repeat (3) @(negedge clk);
        check12("reset_held", {bus.anodes, bus.segments, bus.dp}, 12'hFFF);
        #1 rst = 1'b0;

        // Plain scan of 1234.
        frame(16'h1234, 4'h0, 1'b0, 1'b1, 0, 16'h0, 4'h0);

        // Digit 0 sweeps 0..F, upper digits random.
        for (int v = 0; v < 16; v++) begin
            r = $urandom;
            d = {r[15:4], 4'(v)};
            frame(d, 4'h0, 1'b0, 1'b1, 0, 16'h0, 4'h0);
        end

        // Leading-zero blanking boundaries.
        frame(16'h0070, 4'h0, 1'b1, 1'b1, 0, 16'h0, 4'h0);
        frame(16'h0000, 4'hF, 1'b1, 1'b1, 0, 16'h0, 4'h0);
        frame(16'h0001, 4'b1010, 1'b1, 1'b1, 0, 16'h0, 4'h0);
        frame(16'h0100, 4'h0, 1'b1, 1'b1, 0, 16'h0, 4'h0);
        frame(16'h8000, 4'h0, 1'b1, 1'b1, 0, 16'h0, 4'h0);

        // Mid-frame change while digit 1 is lit stays hidden until next frame.
        frame(16'h1234, 4'b0100, 1'b0, 1'b1, CLK_DIV + 1, 16'h5678, 4'b0100);
        frame(16'h5678, 4'b0100, 1'b0, 1'b1, 0, 16'h0, 4'h0);

        // Display disabled: scan continues, anodes stay off.
        r = $urandom;
        frame(r[15:0], r[19:16], 1'b0, 1'b0, 0, 16'h0, 4'h0);

        // Random frames with random mid-frame disturbance.
        for (int f = 0; f < 20; f++) begin
            r  = $urandom;
            d  = r[15:0];
            p  = r[19:16];
            if (r[20]) d[15:8] = 8'h00;
            r  = $urandom;
            d2 = r[15:0];
            p2 = r[19:16];
            frame(d, p, r[20], (r[23:21] != 3'd0), int'($urandom_range(1, FRAME - 1)), d2, p2);
        end

        // Reset pulse while digit 2 is lit.
        r = $urandom;
        d = r[15:0];
        p = r[19:16];
        bus.data  = d;
        bus.dp_in = p;
        bus.lz_en = 1'b0;
        bus.en    = 1'b1;
        for (int k = 0; k < DIGITS; k++) sb.push_back(model_slot(d, p, 1'b0, 1'b1, k));
        repeat (2 * CLK_DIV + 1) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        sb.delete();
        #1 check12("reset_midscan", {bus.anodes, bus.segments, bus.dp}, 12'hFFF);
        r = $urandom;
        d = r[15:0];
        p = r[19:16];
        bus.data  = d;
        bus.dp_in = p;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        frame(d, p, 1'b0, 1'b1, 0, 16'h0, 4'h0);
        r = $urandom;
        frame(r[15:0], r[19:16], 1'b1, 1'b1, 0, 16'h0, 4'h0);

        // Drain: the last slot must have been compared well inside one slot time.
        for (int t = 0; t < CLK_DIV - 1 && sb.size() != 0; t++) @(negedge clk);
        done = 1'b1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d slots outstanding expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
